// File: rtl/cic3_pkg.sv
// Width derivations shared by the CIC3 integrator and differentiator halves,
// so both sides always agree on counter and datapath widths.
package cic3_pkg;

  function automatic int clock_width(input int decimation_factor);
    return $clog2(decimation_factor);
  endfunction

  // Third-order CIC growth is 3*log2(D) bits on top of the 1-bit input.
  function automatic int num_bits(input int decimation_factor);
    return 3 * $clog2(decimation_factor) + 1;
  endfunction

endpackage

// File: rtl/cic_integrator.sv
// Enabled modulo-2^W accumulator; one stage of the CIC3 integrator cascade.
module cic_integrator #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] acc_o
);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;

  // Wrap-around is intended; the downstream comb section cancels it.
  assign acc_d = acc_q + din_i;

  // NOTE: reset is sampled on the clock edge (synchronous) and wins over en_i.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/cic3_accumulators.sv
// CIC3 decimator front end: three cascaded integrators, decimation counter,
// divided clock and the downsampled output register.
module cic3_accumulators
  import cic3_pkg::*;
#(
  parameter int DECIMATION_FACTOR = 256,
  parameter int CLOCK_WIDTH       = clock_width(DECIMATION_FACTOR),
  parameter int NUMBITS           = num_bits(DECIMATION_FACTOR)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in,
  input  logic               enable,
  output logic [NUMBITS-1:0] out,
  output logic               divided_clk,
  output logic               sample_valid
);

  localparam logic [CLOCK_WIDTH-1:0] LAST_COUNT = CLOCK_WIDTH'(DECIMATION_FACTOR - 1);

  logic [NUMBITS-1:0]     in_ext;
  logic [NUMBITS-1:0]     acc1;
  logic [NUMBITS-1:0]     acc2;
  logic [NUMBITS-1:0]     acc3;
  logic [CLOCK_WIDTH-1:0] count_q;
  logic [CLOCK_WIDTH-1:0] count_d;
  logic [NUMBITS-1:0]     out_q;
  logic                   sample_valid_q;
  logic                   period_end;

  assign in_ext = {{(NUMBITS-1){1'b0}}, in};

  // Each stage adds the previous stage's registered value, so the cascade
  // is pipelined and the input needs three edges to reach acc3.
  cic_integrator #(.W(NUMBITS)) u_int1 (
    .clk(clk), .reset_n(reset_n), .en_i(enable), .din_i(in_ext), .acc_o(acc1)
  );
  cic_integrator #(.W(NUMBITS)) u_int2 (
    .clk(clk), .reset_n(reset_n), .en_i(enable), .din_i(acc1), .acc_o(acc2)
  );
  cic_integrator #(.W(NUMBITS)) u_int3 (
    .clk(clk), .reset_n(reset_n), .en_i(enable), .din_i(acc2), .acc_o(acc3)
  );

  // D is a power of two, so the natural counter wrap is the period wrap.
  assign count_d    = count_q + CLOCK_WIDTH'(1);
  assign period_end = (count_q == LAST_COUNT);

  // NOTE: non-blocking assignments so out_q captures acc3 before its update.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q        <= '0;
      out_q          <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= enable && period_end;
      if (enable) begin
        count_q <= count_d;
        if (period_end) begin
          out_q <= acc3;
        end
      end
    end
  end

  assign out          = out_q;
  assign sample_valid = sample_valid_q;
  assign divided_clk  = ~count_q[CLOCK_WIDTH-1];

endmodule

// File: tb/tb_cic3_accumulators.sv
// Directed bench for cic3_accumulators with D = 8 (CLOCK_WIDTH 3, NUMBITS 10).
module tb_cic3_accumulators;

  localparam int D  = 8;
  localparam int NB = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_s;
  logic          enable;
  logic [NB-1:0] out;
  logic          divided_clk;
  logic          sample_valid;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_ones [3] = '{35, 455, 747};

  cic3_accumulators #(.DECIMATION_FACTOR(D)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in           (in_s),
    .enable       (enable),
    .out          (out),
    .divided_clk  (divided_clk),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    in_s    = 1'b1;
    enable  = 1'b1;

    // Reset held three cycles with ones on the input.
    repeat (3) tick();
    check("rst_out", 32'(out), 0);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_dclk", 32'(divided_clk), 1);

    // Constant ones: samples 35, 455, 747 (1771 wrapped).
    reset_n = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      check($sformatf("ones_dclk_%0d", k), 32'(divided_clk), 32'((k % D) < D / 2));
      check($sformatf("ones_valid_%0d", k), 32'(sample_valid), 32'((k % D) == 0));
      if (k % D == 0) check($sformatf("ones_out_%0d", k), 32'(out), 32'(exp_ones[k / D - 1]));
      if (k == 7) check("ones_out_before_first", 32'(out), 0);
    end

    // All-zero stream: output stays 0, pulses keep coming.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    in_s    = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("zero_valid_%0d", k), 32'(sample_valid), 32'((k % D) == 0));
      if (k % D == 0) check($sformatf("zero_out_%0d", k), 32'(out), 0);
    end

    // Five-cycle stall at count 2 of the second period.
    reset_n = 1'b0;
    in_s    = 1'b1;
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 8) check("stall_first_valid", 32'(sample_valid), 1);
      if (k == 8) check("stall_first_out", 32'(out), 35);
    end
    enable = 1'b0;
    for (int s = 1; s <= 5; s++) begin
      tick();
      check($sformatf("stall_dclk_%0d", s), 32'(divided_clk), 1);
      check($sformatf("stall_valid_%0d", s), 32'(sample_valid), 0);
      check($sformatf("stall_out_%0d", s), 32'(out), 35);
    end
    enable = 1'b1;
    for (int k = 11; k <= 16; k++) begin
      tick();
      check($sformatf("resume_dclk_%0d", k), 32'(divided_clk), 32'((k % D) < D / 2));
      check($sformatf("resume_valid_%0d", k), 32'(sample_valid), 32'(k == 16));
    end
    check("resume_out", 32'(out), 455);

    // Reset at count 5 of the second period.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (13) tick();
    check("mid_out_before", 32'(out), 35);
    check("mid_dclk_before", 32'(divided_clk), 0);
    reset_n = 1'b0;
    tick();
    check("mid_rst_out", 32'(out), 0);
    check("mid_rst_valid", 32'(sample_valid), 0);
    check("mid_rst_dclk", 32'(divided_clk), 1);
    reset_n = 1'b1;
    repeat (7) tick();
    check("post_rst_out_7", 32'(out), 0);
    check("post_rst_valid_7", 32'(sample_valid), 0);
    tick();
    check("post_rst_out_8", 32'(out), 35);
    check("post_rst_valid_8", 32'(sample_valid), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
